// File: rtl/gomoku_win_checker.sv
// rtl/gomoku_win_checker.sv - line-of-WIN_LEN detector around the most recently placed stone
// Walks each of the four lines through pos one cell per cycle, outward in both senses.
module gomoku_win_checker #(
    parameter int N       = 10,
    parameter int WIN_LEN = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [7:0]     pos,
    input  logic [N*N-1:0] board_state,
    input  logic [N*N-1:0] turn_map,
    output logic           busy,
    output logic           done,
    output logic           win,
    output logic           winner,
    output logic [1:0]     win_dir,
    output logic [3:0]     run_len
);

    localparam int                CELLS   = N * N;
    localparam int                IW      = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [8:0]        CELLS_W = 9'(CELLS);
    localparam logic signed [7:0] N_S     = 8'(N);
    localparam logic [3:0]        WIN_W   = 4'(WIN_LEN);
    localparam logic [3:0]        K_LAST  = 4'(WIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WALK_POS,
        S_WALK_NEG,
        S_EVAL,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CELLS-1:0]     r_board;
    logic [CELLS-1:0]     r_turn;
    logic [7:0]           r_pos;
    logic [7:0]           r_row;
    logic [7:0]           r_col;
    logic                 r_colour;
    logic [1:0]           r_dir;
    logic [3:0]           r_count;
    logic [3:0]           r_max;
    logic [3:0]           r_k;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_win;
    logic                 r_winner;
    logic [1:0]           r_win_dir;
    logic [3:0]           r_run_len;
    logic                 r_res_win;
    logic [1:0]           r_res_dir;
    logic [3:0]           r_res_len;

    logic                 w_accept;
    logic [IW-1:0]        w_pos_idx;
    logic                 w_valid;
    logic signed [7:0]    w_koff;
    logic signed [7:0]    w_dr_off;
    logic signed [7:0]    w_dc_off;
    logic signed [7:0]    w_tr;
    logic signed [7:0]    w_tc;
    logic                 w_inb;
    logic [IW-1:0]        w_cell_idx;
    logic                 w_match;
    logic                 w_walk_end;
    logic                 w_is_win;
    logic [3:0]           w_max_next;

    // The done-pulse cycle is already back in IDLE, so r_done blocks a start there.
    assign w_accept  = start && !r_done;
    assign w_pos_idx = r_pos[IW-1:0];
    assign w_valid   = ({1'b0, r_pos} < CELLS_W) && r_board[w_pos_idx];
    assign w_koff    = $signed({4'b0000, r_k});

    always_comb begin
        w_dr_off = '0;
        w_dc_off = '0;
        if (r_dir != 2'd0) begin
            w_dr_off = w_koff;
        end
        case (r_dir)
            2'd1:    w_dc_off = '0;
            2'd3:    w_dc_off = -w_koff;
            default: w_dc_off = w_koff;
        endcase
        if (r_state == S_WALK_NEG) begin
            w_dr_off = -w_dr_off;
            w_dc_off = -w_dc_off;
        end
    end

    // Bounds are checked on row/col so a run can never wrap across a row edge.
    assign w_tr       = $signed(r_row) + w_dr_off;
    assign w_tc       = $signed(r_col) + w_dc_off;
    assign w_inb      = !w_tr[7] && !w_tc[7] && (w_tr < N_S) && (w_tc < N_S);
    assign w_cell_idx = IW'({8'd0, w_tr} * 16'(N) + {8'd0, w_tc});
    assign w_match    = w_inb && r_board[w_cell_idx] && (r_turn[w_cell_idx] == r_colour);
    assign w_walk_end = !w_match || (r_k == K_LAST);
    assign w_is_win   = (r_count >= WIN_W);
    assign w_max_next = (r_count > r_max) ? r_count : r_max;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_next = S_LOAD;
            S_LOAD:     w_next = w_valid ? S_WALK_POS : S_DONE;
            S_WALK_POS: if (w_walk_end) w_next = S_WALK_NEG;
            S_WALK_NEG: if (w_walk_end) w_next = S_EVAL;
            S_EVAL:     w_next = (w_is_win || (r_dir == 2'd3)) ? S_DONE : S_WALK_POS;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_board   <= '0;
            r_turn    <= '0;
            r_pos     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_colour  <= 1'b0;
            r_dir     <= '0;
            r_count   <= '0;
            r_max     <= '0;
            r_k       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_win     <= 1'b0;
            r_winner  <= 1'b0;
            r_win_dir <= '0;
            r_run_len <= '0;
            r_res_win <= 1'b0;
            r_res_dir <= '0;
            r_res_len <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_board <= board_state;
                        r_turn  <= turn_map;
                        r_pos   <= pos;
                    end
                end
                S_LOAD: begin
                    r_row     <= r_pos / 8'(N);
                    r_col     <= r_pos % 8'(N);
                    r_colour  <= w_valid && r_turn[w_pos_idx];
                    r_dir     <= '0;
                    r_count   <= 4'd1;
                    r_max     <= '0;
                    r_k       <= 4'd1;
                    r_res_win <= 1'b0;
                    r_res_dir <= '0;
                    r_res_len <= '0;
                end
                S_WALK_POS, S_WALK_NEG: begin
                    if (w_match) begin
                        r_count <= r_count + 4'd1;
                    end
                    r_k <= w_walk_end ? 4'd1 : r_k + 4'd1;
                end
                S_EVAL: begin
                    if (w_is_win) begin
                        r_res_win <= 1'b1;
                        r_res_dir <= r_dir;
                        r_res_len <= r_count;
                    end else if (r_dir != 2'd3) begin
                        r_max   <= w_max_next;
                        r_count <= 4'd1;
                        r_dir   <= r_dir + 2'd1;
                    end else begin
                        // Anti-diagonal count is not folded into max_len on the last pass.
                        r_res_win <= 1'b0;
                        r_res_dir <= '0;
                        r_res_len <= r_max;
                    end
                end
                S_DONE: begin
                    r_win     <= r_res_win;
                    r_winner  <= r_colour;
                    r_win_dir <= r_res_dir;
                    r_run_len <= r_res_len;
                end
                default: ;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign win     = r_win;
    assign winner  = r_winner;
    assign win_dir = r_win_dir;
    assign run_len = r_run_len;

endmodule

// File: tb/tb_gomoku_win_checker.sv
// tb/tb_gomoku_win_checker.sv - directed and randomized checks of gomoku_win_checker
module tb_gomoku_win_checker;

    localparam int N       = 10;
    localparam int WIN_LEN = 5;
    localparam int MAXLAT  = 3 + 4 * (2 * (WIN_LEN - 1) + 1);

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   pos;
    logic [N*N-1:0] board_state;
    logic [N*N-1:0] turn_map;
    logic         busy;
    logic         done;
    logic         win;
    logic         winner;
    logic [1:0]   win_dir;
    logic [3:0]   run_len;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gomoku_win_checker #(.N(N), .WIN_LEN(WIN_LEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pos         (pos),
        .board_state (board_state),
        .turn_map    (turn_map),
        .busy        (busy),
        .done        (done),
        .win         (win),
        .winner      (winner),
        .win_dir     (win_dir),
        .run_len     (run_len)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: count matching stones outward from p along each line, first direction to reach WIN_LEN wins.
    function automatic void ref_check(input logic [N*N-1:0] b, input logic [N*N-1:0] t, input int p,
                                      output logic ew, output logic ewn,
                                      output logic [1:0] ed, output logic [3:0] el);
        int r0, c0, best, cnt, dr, dc, rr, cc;
        ew = 1'b0; ewn = 1'b0; ed = 2'd0; el = 4'd0;
        if (p < 0 || p >= N * N) return;
        if (!b[p]) return;
        ewn  = t[p];
        r0   = p / N;
        c0   = p % N;
        best = 0;
        for (int d = 0; d < 4; d++) begin
            dr  = (d == 0) ? 0 : 1;
            dc  = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
            cnt = 1;
            for (int s = -1; s <= 1; s += 2) begin
                for (int k = 1; k < WIN_LEN; k++) begin
                    rr = r0 + s * k * dr;
                    cc = c0 + s * k * dc;
                    if (rr < 0 || rr >= N || cc < 0 || cc >= N) break;
                    if (!b[rr * N + cc] || t[rr * N + cc] != t[p]) break;
                    cnt++;
                end
            end
            if (cnt >= WIN_LEN) begin
                ew = 1'b1; ed = 2'(d); el = 4'(cnt);
                return;
            end
            if (d < 3 && cnt > best) best = cnt;
        end
        el = 4'(best);
    endfunction

    function automatic logic [N*N-1:0] rnd_cells();
        logic [127:0] x;
        x = {$urandom(), $urandom(), $urandom(), $urandom()};
        return x[N*N-1:0];
    endfunction

    task automatic run(input int p, input bit scramble, input bit restart,
                       output int lat, output bit to, output logic busy1);
        @(negedge clk);
        pos   = 8'(p);
        start = 1'b1;
        lat   = 0;
        to    = 1'b1;
        busy1 = 1'b0;
        for (int i = 0; i < MAXLAT + 10; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            if (lat == 1) busy1 = busy;
            if (scramble) begin
                board_state = rnd_cells();
                turn_map    = rnd_cells();
                pos         = 8'($urandom);
            end
            if (done) begin
                to = 1'b0;
                break;
            end
            if (restart && lat == 2) begin
                start = 1'b1;
                pos   = 8'($urandom_range(0, N * N - 1));
            end
        end
    endtask

    task automatic verify(input string tag, input int p, input logic [N*N-1:0] b, input logic [N*N-1:0] t,
                          input logic ew, input logic ewn, input logic [1:0] ed, input logic [3:0] el,
                          input bit scramble, input bit restart, input bit start_in_done);
        int   lat;
        bit   to;
        logic busy1;
        logic invalid;
        board_state = b;
        turn_map    = t;
        invalid     = (p >= N * N) || !b[p];
        run(p, scramble, restart, lat, to, busy1);
        check({tag, " done_seen"}, 32'(!to), 32'd1);
        check({tag, " busy_after_start"}, 32'(busy1), 32'd1);
        if (!to) begin
            check({tag, " win"},     32'(win),     32'(ew));
            check({tag, " winner"},  32'(winner),  32'(ewn));
            check({tag, " win_dir"}, 32'(win_dir), 32'(ed));
            check({tag, " run_len"}, 32'(run_len), 32'(el));
            check({tag, " busy_in_done"}, 32'(busy), 32'd0);
            if (invalid) check({tag, " latency"}, 32'(lat), 32'd3);
            else         check({tag, " latency_le_max"}, 32'(lat <= MAXLAT), 32'd1);
            if (start_in_done) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check({tag, " done_one_cycle"}, 32'(done), 32'd0);
            check({tag, " win_hold"}, 32'(win), 32'(ew));
            if (start_in_done) check({tag, " start_in_done_ignored"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic expect_no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*N-1:0] b, t;
        logic ew, ewn;
        logic [1:0] ed;
        logic [3:0] el;
        int p, d, len, sh, r0, c0, rr, cc, dr, dc;

        rst = 1'b1; start = 1'b0; pos = '0; board_state = '0; turn_map = '0;
        #1;
        check("reset_outputs", 32'({busy, done, win, winner, win_dir, run_len}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Black horizontal five; a second start during busy must be ignored.
        b = '0; t = '0;
        for (int c = 40; c <= 44; c++) b[c] = 1'b1;
        verify("h_black", 42, b, t, 1'b1, 1'b0, 2'd0, 4'd5, 1'b0, 1'b1, 1'b0);
        expect_no_done("h_black no_second_done", 50);

        // White run broken by the row edge: no wrap-around win.
        b = '0; t = '0;
        for (int c = 7; c <= 11; c++) begin b[c] = 1'b1; t[c] = 1'b1; end
        verify("row_wrap", 9, b, t, 1'b0, 1'b1, 2'd0, 4'd3, 1'b1, 1'b0, 1'b0);

        // White anti-diagonal; start held during the done cycle.
        b = '0; t = '0;
        foreach (b[i]) if (i == 4 || i == 13 || i == 22 || i == 31 || i == 40) begin b[i] = 1'b1; t[i] = 1'b1; end
        verify("anti_diag", 22, b, t, 1'b1, 1'b1, 2'd3, 4'd5, 1'b0, 1'b0, 1'b1);

        // Black vertical overline of six.
        b = '0; t = '0;
        for (int r = 0; r <= 5; r++) b[r * N + 5] = 1'b1;
        verify("vert_six", 25, b, t, 1'b1, 1'b0, 2'd1, 4'd6, 1'b0, 1'b0, 1'b0);

        verify("empty_cell", 50, b, t, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        verify("pos_oob", 120, b, t, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Abort by reset five cycles into a check.
        b = '0; t = '0;
        for (int c = 40; c <= 44; c++) b[c] = 1'b1;
        board_state = b; turn_map = t;
        @(negedge clk); pos = 8'd42; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("abort busy", 32'(busy), 32'd1);
        @(negedge clk); start = 1'b1; pos = 8'd9;
        @(negedge clk); start = 1'b0;
        check("abort no_early_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort reset_outputs", 32'({busy, done, win, winner, win_dir, run_len}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_no_done("abort no_done", 50);
        verify("after_abort", 42, b, t, 1'b1, 1'b0, 2'd0, 4'd5, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            b = rnd_cells();
            t = rnd_cells();
            p = ($urandom_range(0, 7) == 0) ? int'($urandom_range(100, 255)) : int'($urandom_range(0, N * N - 1));
            if (p < N * N && $urandom_range(0, 9) != 0) b[p] = 1'b1;
            if (p < N * N && b[p] && $urandom_range(0, 1) == 1) begin
                d   = int'($urandom_range(0, 3));
                len = int'($urandom_range(3, 8));
                sh  = int'($urandom_range(0, len - 1));
                dr  = (d == 0) ? 0 : 1;
                dc  = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
                r0  = p / N;
                c0  = p % N;
                for (int i = 0; i < len; i++) begin
                    rr = r0 + (i - sh) * dr;
                    cc = c0 + (i - sh) * dc;
                    if (rr >= 0 && rr < N && cc >= 0 && cc < N) begin
                        b[rr * N + cc] = 1'b1;
                        t[rr * N + cc] = t[p];
                    end
                end
            end
            ref_check(b, t, p, ew, ewn, ed, el);
            verify($sformatf("rnd%0d", n), p, b, t, ew, ewn, ed, el, n[0], n[1], 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gomoku_win_checker.md
GOMOKU_WIN_CHECKER -- requirements
Module: gomoku_win_checker

Interface
REQ-001 The module SHALL have parameter N, default 10, meaning the board side length; the board holds N*N cells and cell index = row*N + col.
REQ-002 The module SHALL have parameter WIN_LEN, default 5, meaning the minimum run of same-colour stones that counts as a win.
REQ-003 The module SHALL have port clk, input, width 1: the clock; all state changes occur on its rising edge.
REQ-004 The module SHALL have port rst, input, width 1: reset, asynchronous, active-high.
REQ-005 The module SHALL have port start, input, width 1: single-cycle request to check the stone at pos.
REQ-006 The module SHALL have port pos, input, width 8: index of the most recently placed cell.
REQ-007 The module SHALL have port board_state, input, width N*N: 1 = cell occupied.
REQ-008 The module SHALL have port turn_map, input, width N*N: stone colour, 1 = white, 0 = black; meaningful only where board_state = 1.
REQ-009 The module SHALL have port busy, output, width 1: high while a check is in progress.
REQ-010 The module SHALL have port done, output, width 1: one-cycle pulse when a check completes.
REQ-011 The module SHALL have port win, output, width 1: result flag, 1 = WIN_LEN or more in a line.
REQ-012 The module SHALL have port winner, output, width 1: colour of the checked stone, 1 = white.
REQ-013 The module SHALL have port win_dir, output, width 2: winning direction, where 0 = horizontal, 1 = vertical, 2 = diagonal (down-right) and 3 = anti-diagonal (down-left).
REQ-014 The module SHALL have port run_len, output, width 4: run length reported for the check.

Function
REQ-015 A start sampled high in IDLE SHALL snapshot board_state, turn_map and pos into internal registers, assert busy on the next cycle and move to LOAD; later input changes SHALL NOT affect the check.
REQ-016 A start sampled while busy=1 SHALL be ignored.
REQ-017 LOAD SHALL decode row = pos/N and col = pos%N, latch colour = turn_map[pos], set the direction to 0 and count to 1.
REQ-018 LOAD invalid cases: if pos >= N*N or board_state[pos] = 0, the FSM SHALL go straight to DONE with win=0, run_len=0, winner=0 and win_dir=0.
REQ-019 FSM states SHALL be IDLE, LOAD, WALK_POS, WALK_NEG, EVAL, DONE.
REQ-020 WALK_POS SHALL examine exactly one cell per cycle at offset k = 1, 2, ... along +direction, with (dr,dc) per direction = (0,+1), (+1,0), (+1,+1), (+1,-1).
REQ-021 Each WALK_POS step SHALL increment count only if the cell is in-bounds (0 <= row, col < N, computed on row/col, never on the linear index), occupied and the same colour.
REQ-022 WALK_POS SHALL stop at the first failing cell or after k = WIN_LEN-1, then go to WALK_NEG.
REQ-023 WALK_NEG SHALL walk the opposite direction under the same rules, then go to EVAL.
REQ-024 Count SHALL therefore never exceed 2*(WIN_LEN-1)+1 (9 at default).
REQ-025 EVAL SHALL end the check when count >= WIN_LEN (overlines count as wins): go to DONE with win=1, win_dir = current direction, run_len = count.
REQ-026 When EVAL does not end the check and direction < 3, EVAL SHALL record max_len = max(max_len, count), reset count to 1, increment direction and go to WALK_POS.
REQ-027 When EVAL does not end the check and direction = 3, EVAL SHALL go to DONE with win=0, win_dir=0, run_len = max_len.
REQ-028 DONE SHALL pulse done for exactly one cycle, drop busy in the same cycle and return to IDLE.
REQ-029 win, winner, win_dir and run_len SHALL update only in the DONE cycle and SHALL hold until the next DONE.
REQ-030 Latency from start to done SHALL be <= 3 + 4*(2*(WIN_LEN-1)+1) cycles (39 at default), and exactly 3 cycles for the invalid case.
REQ-031 A start coinciding with the DONE cycle SHALL be ignored; start is accepted only in IDLE.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, with busy, done, win, winner, win_dir and run_len all 0, and internal count and max_len cleared.
REQ-033 Reset during any state SHALL abort the check without a done pulse.
REQ-034 The first start after rst is released SHALL be processed normally.

Verification
REQ-035 The bench SHALL cover: black at 40..44, start pos=42 -> done within 39 cycles, win=1, winner=0, win_dir=0, run_len=5.
REQ-036 The bench SHALL cover: white at 7, 8, 9, 10, 11 (row-edge wrap), start pos=9 -> win=0, run_len=3, no false horizontal win.
REQ-037 The bench SHALL cover: white at 4, 13, 22, 31, 40, start pos=22 -> win=1, winner=1, win_dir=3, run_len=5.
REQ-038 The bench SHALL cover: black at 5, 15, 25, 35, 45, 55, start pos=25 -> win=1, win_dir=1, run_len=6.
REQ-039 The bench SHALL cover: start pos=50 on an empty cell, and pos=120 -> done exactly 3 cycles after start, win=0, run_len=0.
REQ-040 The bench SHALL cover: start, then a second start during busy, then rst pulsed 5 cycles in -> second start ignored, busy=0 immediately, no done; a fresh start afterwards completes correctly.
